// File: rtl/axil_seq_pkg.sv
// Shared types and constants for the AXI4-Lite sequencing master.
package axil_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_WR_VERIFY  = 2'd0,
    MODE_WR_ONLY    = 2'd1,
    MODE_RD_CHECK   = 2'd2,
    MODE_RD_NOCHECK = 2'd3
  } mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_CNT_W = 8;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  function automatic logic mode_checks_data(input mode_e mode);
    return (mode == MODE_WR_VERIFY) || (mode == MODE_RD_CHECK);
  endfunction

endpackage

// File: rtl/axil_seq_watchdog.sv
// Handshake watchdog: pulses expire_o after C_TIMEOUT consecutive active
// cycles with no handshake. Only instantiated with AXIL_SEQ_TIMEOUT_EN.
module axil_seq_watchdog #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int CW = $clog2(C_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (!active_i || kick_i) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      expire_o = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axil_seq_master.sv
// AXI4-Lite sequencing master: write/verify/read-check runs over a contiguous
// window against a seeded pattern. Optional watchdog via AXIL_SEQ_TIMEOUT_EN.
module axil_seq_master
  import axil_seq_pkg::*;
#(
  parameter int                    C_ADDR_WIDTH = 32,
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_NUM_TXNS   = 4,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h4000_0000,
  parameter int                    C_TIMEOUT    = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      INIT_TXN,
  input  logic [1:0]                MODE,
  input  logic [C_DATA_WIDTH-1:0]   SEED,
  output logic                      TXN_DONE,
  output logic                      ERROR,
  output logic [ERR_CNT_W-1:0]      ERR_COUNT,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int BYTE_SHIFT = (C_DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W      = (C_NUM_TXNS > 1) ? $clog2(C_NUM_TXNS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_TXNS - 1);

  state_e                 state_q, state_d;
  mode_e                  mode_q;
  logic [C_DATA_WIDTH-1:0] seed_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   aw_done_q, w_done_q;
  logic                   init_q, start_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_req_done, last_idx, start_ok, err_inc, timeout;
  logic [C_DATA_WIDTH-1:0] pattern;
  logic [C_ADDR_WIDTH-1:0] addr;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;

  // Address and data come from registered index/seed only, so they stay
  // stable while a valid is pending.
  assign pattern  = seed_q + C_DATA_WIDTH'(idx_q);
  assign addr     = C_BASE_ADDR + (C_ADDR_WIDTH'(idx_q) << BYTE_SHIFT);
  assign last_idx = (idx_q == LAST_IDX);
  assign start_ok = start_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign wr_req_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

`ifdef AXIL_SEQ_TIMEOUT_EN
  logic wd_active;
  assign wd_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

  axil_seq_watchdog #(.C_TIMEOUT(C_TIMEOUT)) u_watchdog (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .active_i (wd_active),
    .kick_i   (aw_hs | w_hs | b_hs | ar_hs | r_hs),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A timeout never coincides with a handshake, so at most one increment per beat.
  assign err_inc = (b_hs && resp_is_err(M_AXI_BRESP)) ||
                   (r_hs && (resp_is_err(M_AXI_RRESP) ||
                             (mode_checks_data(mode_q) && (M_AXI_RDATA != pattern)))) ||
                   timeout;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = MODE[1] ? ST_RD_REQ : ST_WR_REQ;
      ST_WR_REQ:  if (wr_req_done) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) begin
        if (!last_idx)                        state_d = ST_WR_REQ;
        else if (mode_q == MODE_WR_VERIFY)    state_d = ST_RD_REQ;
        else                                  state_d = ST_DONE;
      end
      ST_RD_REQ:  if (ar_hs) state_d = ST_RD_RESP;
      ST_RD_RESP: if (r_hs) state_d = last_idx ? ST_DONE : ST_RD_REQ;
      default:    state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_DONE;
  end

  // Handshake-facing outputs decode the state register only, so an async
  // reset drops them at once and no VALID waits on a READY.
  always_comb begin
    M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
    M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
    M_AXI_BREADY  = (state_q == ST_WR_RESP);
    M_AXI_ARVALID = (state_q == ST_RD_REQ);
    M_AXI_RREADY  = (state_q == ST_RD_RESP);
    TXN_DONE      = (state_q == ST_DONE);
  end

  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA  = pattern;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign ERR_COUNT    = err_cnt_q;
  assign ERROR        = (err_cnt_q != '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q    <= 1'b0;
      start_q   <= 1'b0;
      mode_q    <= MODE_WR_VERIFY;
      seed_q    <= '0;
      idx_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      init_q  <= INIT_TXN;
      start_q <= INIT_TXN & ~init_q;
      if (start_ok) begin
        mode_q    <= mode_e'(MODE);
        seed_q    <= SEED;
        idx_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        if (timeout || (state_q == ST_WR_REQ && wr_req_done)) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else if (state_q == ST_WR_REQ) begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        if (b_hs || r_hs) idx_q <= last_idx ? '0 : idx_q + 1'b1;
        if (err_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_seq_master.sv
// Self-checking bench for axil_seq_master with a memory-model AXI4-Lite slave
// and an address/data scoreboard. Timeout scenario runs with AXIL_SEQ_TIMEOUT_EN.
module tb_axil_seq_master;
  import axil_seq_pkg::*;

  localparam int          NT   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        ACLK = 1'b0, ARESETN = 1'b0, INIT_TXN = 1'b0;
  logic [1:0]  MODE = 2'd0;
  logic [31:0] SEED = '0;
  logic        TXN_DONE, ERROR;
  logic [7:0]  ERR_COUNT;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration, written only by the test tasks.
  int aw_delay = 0, slverr_idx = -1, corrupt_idx = -1;
  bit aw_never = 1'b0, w_never = 1'b0;

  // Slave state and observation log, written only by the slave process.
  logic [31:0] mem [0:15];
  logic [63:0] obs_wr [0:255];
  logic [31:0] obs_rd [0:255];
  int obs_wr_n = 0, obs_rd_n = 0, aw_hi_n = 0, w_hi_n = 0, b_n = 0, aw_wait = 0;
  logic [31:0] aw_l, w_l, ar_l;
  logic aw_have, w_have, ar_have;

  // Bench-side model and scoreboard queues.
  logic [31:0] mem_model [0:15];
  logic [63:0] exp_wr [$];
  logic [31:0] exp_rd [$];

  always #5 ACLK = ~ACLK;

  axil_seq_master #(
    .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_NUM_TXNS(NT),
    .C_BASE_ADDR(BASE), .C_TIMEOUT(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .INIT_TXN(INIT_TXN), .MODE(MODE), .SEED(SEED),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 15;
  endfunction

  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_never && (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_never;
  assign M_AXI_ARREADY = M_AXI_ARVALID;

  always @(posedge ACLK or negedge ARESETN) begin : slave
    int wi;
    if (!ARESETN) begin
      aw_wait <= 0; aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= RESP_OKAY;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= RESP_OKAY; M_AXI_RDATA <= '0;
    end else begin
      if (M_AXI_AWVALID) aw_hi_n <= aw_hi_n + 1;
      if (M_AXI_WVALID)  w_hi_n  <= w_hi_n + 1;
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_wait <= 0;
      else if (M_AXI_AWVALID)             aw_wait <= aw_wait + 1;
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0;
        b_n <= b_n + 1;
      end
      if (aw_have && w_have && !M_AXI_BVALID) begin
        wi = widx(aw_l);
        mem[wi] <= w_l;
        obs_wr[obs_wr_n] <= {aw_l, w_l};
        obs_wr_n <= obs_wr_n + 1;
        M_AXI_BRESP  <= (wi == slverr_idx) ? RESP_SLVERR : RESP_OKAY;
        M_AXI_BVALID <= 1'b1;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_l <= M_AXI_AWADDR; aw_have <= 1'b1; end
      if (M_AXI_WVALID && M_AXI_WREADY)   begin w_l  <= M_AXI_WDATA;  w_have  <= 1'b1; end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (ar_have && !M_AXI_RVALID) begin
        wi = widx(ar_l);
        M_AXI_RDATA  <= (wi == corrupt_idx) ? 32'h0 : mem[wi];
        M_AXI_RRESP  <= RESP_OKAY;
        M_AXI_RVALID <= 1'b1;
        ar_have <= 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_l <= M_AXI_ARADDR;
        ar_have <= 1'b1;
        obs_rd[obs_rd_n] <= M_AXI_ARADDR;
        obs_rd_n <= obs_rd_n + 1;
      end
    end
  end

  // Drives a start pulse, pushes the expected traffic and checks start latency.
  task automatic do_start(input logic [1:0] mode, input logic [31:0] seed);
    logic first_valid;
    for (int i = 0; i < NT; i++) begin
      if (mode != 2'd2 && mode != 2'd3) exp_wr.push_back({BASE + 32'(4 * i), seed + 32'(i)});
      if (mode != 2'd1) exp_rd.push_back(BASE + 32'(4 * i));
    end
    MODE = mode;
    SEED = seed;
    @(posedge ACLK); #1 INIT_TXN = 1'b1;
    @(posedge ACLK); #1;
    n_cmp++;
    if ({M_AXI_AWVALID, M_AXI_ARVALID} !== 2'b00) begin
      n_bad++;
      $display("FAIL start_latency_early got aw=%b ar=%b exp 0", M_AXI_AWVALID, M_AXI_ARVALID);
    end
    @(posedge ACLK); #1;
    first_valid = mode[1] ? M_AXI_ARVALID : M_AXI_AWVALID;
    n_cmp++;
    if (first_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL start_latency got valid=%b exp 1 (mode %0d)", first_valid, mode);
    end
    INIT_TXN = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (TXN_DONE !== 1'b1 && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    n_cmp++;
    if (TXN_DONE !== 1'b1) begin
      n_bad++;
      $display("FAIL done_wait got TXN_DONE=%b after %0d cycles exp 1", TXN_DONE, n);
    end
  endtask

  task automatic check_sb(input string tag, input int wb, input int rb);
    logic [63:0] ew;
    logic [31:0] er;
    n_cmp++;
    if (obs_wr_n - wb != exp_wr.size()) begin
      n_bad++;
      $display("FAIL %s_wr_count got %0d exp %0d", tag, obs_wr_n - wb, exp_wr.size());
    end
    for (int i = 0; i < obs_wr_n - wb && exp_wr.size() > 0; i++) begin
      ew = exp_wr.pop_front();
      n_cmp++;
      if (obs_wr[wb + i] !== ew) begin
        n_bad++;
        $display("FAIL %s_wr%0d got %h exp %h", tag, i, obs_wr[wb + i], ew);
      end
    end
    n_cmp++;
    if (obs_rd_n - rb != exp_rd.size()) begin
      n_bad++;
      $display("FAIL %s_rd_count got %0d exp %0d", tag, obs_rd_n - rb, exp_rd.size());
    end
    for (int i = 0; i < obs_rd_n - rb && exp_rd.size() > 0; i++) begin
      er = exp_rd.pop_front();
      n_cmp++;
      if (obs_rd[rb + i] !== er) begin
        n_bad++;
        $display("FAIL %s_rd%0d got %h exp %h", tag, i, obs_rd[rb + i], er);
      end
    end
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic check_status(input string tag, input logic done, input logic [7:0] cnt);
    n_cmp++;
    if ({TXN_DONE, ERROR, ERR_COUNT} !== {done, cnt != 8'd0, cnt}) begin
      n_bad++;
      $display("FAIL %s_status got done=%b err=%b cnt=%0d exp done=%b err=%b cnt=%0d",
               tag, TXN_DONE, ERROR, ERR_COUNT, done, cnt != 8'd0, cnt);
    end
  endtask

  task automatic run_write_model(input logic [31:0] seed);
    for (int i = 0; i < NT; i++) mem_model[i] = seed + 32'(i);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         TXN_DONE, ERROR, ERR_COUNT} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b done=%b err=%b cnt=%0d exp all 0",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
               TXN_DONE, ERROR, ERR_COUNT);
    end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check_status("idle", 1'b0, 8'd0);
    n_cmp++;
    if ({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT} !== {4'hF, 3'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL const_outputs got strb=%h awprot=%0d arprot=%0d exp F 0 0",
               M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT);
    end
  endtask

  task automatic test_write_verify();
    int wb = obs_wr_n, rb = obs_rd_n;
    do_start(2'd0, 32'hA5A5_0000);
    wait_done(200);
    run_write_model(32'hA5A5_0000);
    check_status("mode0", 1'b1, 8'd0);
    check_sb("mode0", wb, rb);
  endtask

  task automatic test_slverr();
    int wb = obs_wr_n, rb = obs_rd_n, bb = b_n;
    slverr_idx = 2;
    do_start(2'd1, 32'h1234_0000);
    wait_done(200);
    run_write_model(32'h1234_0000);
    check_status("slverr", 1'b1, 8'd1);
    n_cmp++;
    if (b_n - bb != NT) begin
      n_bad++;
      $display("FAIL slverr_b_count got %0d exp %0d", b_n - bb, NT);
    end
    check_sb("slverr", wb, rb);
    slverr_idx = -1;
  endtask

  task automatic test_read_check();
    int wb, rb;
    logic [7:0] exp_cnt;
    logic [31:0] seeds [3] = '{32'h1234_0000, 32'h1234_0000, 32'h0000_0000};
    logic [1:0]  modes [3] = '{2'd2, 2'd3, 2'd2};
    corrupt_idx = 3;
    for (int k = 0; k < 3; k++) begin
      exp_cnt = 8'd0;
      if (modes[k] == 2'd2)
        for (int i = 0; i < NT; i++)
          if (((i == corrupt_idx) ? 32'h0 : mem_model[i]) != seeds[k] + 32'(i)) exp_cnt++;
      wb = obs_wr_n;
      rb = obs_rd_n;
      do_start(modes[k], seeds[k]);
      wait_done(200);
      check_status($sformatf("rdchk%0d", k), 1'b1, exp_cnt);
      check_sb($sformatf("rdchk%0d", k), wb, rb);
    end
    corrupt_idx = -1;
  endtask

  task automatic test_backpressure();
    int wb = obs_wr_n, rb = obs_rd_n, ab = aw_hi_n, vb = w_hi_n, bb = b_n;
    aw_delay = 3;
    do_start(2'd1, 32'h0000_0055);
    wait_done(300);
    run_write_model(32'h0000_0055);
    check_status("bp", 1'b1, 8'd0);
    n_cmp++;
    if ({aw_hi_n - ab, w_hi_n - vb, b_n - bb} !== {32'(4 * NT), 32'(NT), 32'(NT)}) begin
      n_bad++;
      $display("FAIL bp_valid_cycles got aw=%0d w=%0d b=%0d exp aw=%0d w=%0d b=%0d",
               aw_hi_n - ab, w_hi_n - vb, b_n - bb, 4 * NT, NT, NT);
    end
    check_sb("bp", wb, rb);
    aw_delay = 0;
  endtask

  task automatic test_restart_ignored();
    int wb = obs_wr_n, rb = obs_rd_n, n = 0;
    do_start(2'd0, 32'hCAFE_0000);
    while (obs_wr_n == wb && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    INIT_TXN = 1'b1;
    repeat (2) @(negedge ACLK);
    INIT_TXN = 1'b0;
    wait_done(200);
    run_write_model(32'hCAFE_0000);
    repeat (10) @(negedge ACLK);
    check_status("restart", 1'b1, 8'd0);
    check_sb("restart", wb, rb);
  endtask

  task automatic test_reset_mid_run();
    int wb, rb, n = 0;
    do_start(2'd0, 32'h7777_0000);
    while (M_AXI_BREADY !== 1'b1 && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    n_cmp++;
    if (M_AXI_BREADY !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_reach_wr_resp got BREADY=%b exp 1", M_AXI_BREADY);
    end
    ARESETN = 1'b0;
    #1;
    n_cmp++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         TXN_DONE, ERROR, ERR_COUNT} !== 15'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs got aw=%b w=%b b=%b ar=%b r=%b done=%b exp all 0",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, TXN_DONE);
    end
    exp_wr.delete();
    exp_rd.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    wb = obs_wr_n;
    rb = obs_rd_n;
    do_start(2'd0, 32'h0BAD_0000);
    wait_done(200);
    run_write_model(32'h0BAD_0000);
    check_status("after_reset", 1'b1, 8'd0);
    check_sb("after_reset", wb, rb);
  endtask

`ifdef AXIL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int wb = obs_wr_n, rb = obs_rd_n, ab = aw_hi_n;
    aw_never = 1'b1;
    w_never  = 1'b1;
    do_start(2'd1, 32'h0000_0000);
    exp_wr.delete();
    wait_done(100);
    check_status("timeout", 1'b1, 8'd1);
    n_cmp++;
    if ({M_AXI_AWVALID, aw_hi_n - ab} !== {1'b0, 32'd16}) begin
      n_bad++;
      $display("FAIL timeout_awvalid got awvalid=%b cycles=%0d exp 0 16",
               M_AXI_AWVALID, aw_hi_n - ab);
    end
    check_sb("timeout", wb, rb);
    aw_never = 1'b0;
    w_never  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_verify();
    test_slverr();
    test_read_check();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_run();
`ifdef AXIL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
